// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encoding, port indices and default widths shared by the mem_arbiter files.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DATA, LOCKED} state_t;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// mem_arbiter_rr_pick2: two-way round-robin chooser, a contested grant goes to the port not served last.
module mem_arbiter_rr_pick2 (
    input  logic [1:0] pending,
    input  logic       last_served,
    output logic       grant,
    output logic       grant_idx
);
    always_comb begin
        grant     = |pending;
        grant_idx = &pending ? ~last_served : pending[1];
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port byte memory between two clients, one access in flight.
// Define MEM_ARB_LOCK_EN to add p0_lock/p1_lock, letting a granted locked port keep the memory for bursts.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_read,
    input  logic                  p0_write,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic                  p0_rvalid,
    input  logic                  p1_read,
    input  logic                  p1_write,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic                  p1_rvalid,
`ifdef MEM_ARB_LOCK_EN
    input  logic                  p0_lock,
    input  logic                  p1_lock,
`endif
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    state_t                state;
    logic                  owner, last_served, locked, grant, gidx, sel_write, sel_lock;
    logic [1:0]            pend, cand;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign rdata = mem_rdata;
    assign pend  = {p1_read | p1_write, p0_read | p0_write};

`ifdef MEM_ARB_LOCK_EN
    // while the holder keeps its lock high, only the holder is eligible
    assign cand     = (state == LOCKED && (owner ? p1_lock : p0_lock)) ? pend & (owner ? 2'b10 : 2'b01) : pend;
    assign sel_lock = gidx ? p1_lock : p0_lock;
`else
    assign cand     = pend;
    assign sel_lock = 1'b0;
`endif

    mem_arbiter_rr_pick2 u_pick (
        .pending     (cand),
        .last_served (last_served),
        .grant       (grant),
        .grant_idx   (gidx)
    );

    // a port asserting read and write together is served as a write
    always_comb begin
        sel_write = gidx ? p1_write : p0_write;
        sel_addr  = gidx ? p1_addr  : p0_addr;
        sel_wdata = gidx ? p1_wdata : p0_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= PORT0;
            last_served <= PORT1;
            locked      <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p0_rvalid   <= 1'b0;
            p1_rvalid   <= 1'b0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            case (state)
                IDLE, LOCKED: if (grant) begin
                    owner       <= gidx;
                    last_served <= gidx;
                    locked      <= sel_lock;
                    mem_write   <= sel_write;
                    mem_read    <= ~sel_write;
                    mem_addr    <= sel_addr;
                    mem_wdata   <= sel_wdata;
                    p0_ack      <= gidx == PORT0;
                    p1_ack      <= gidx == PORT1;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    p0_rvalid <= mem_read && owner == PORT0;
                    p1_rvalid <= mem_read && owner == PORT1;
                    state     <= mem_read ? DATA : (locked ? LOCKED : IDLE);
                end
                default: state <= locked ? LOCKED : IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter with a behavioural memory and a transaction-level grant model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_read = 1'b0, p0_write = 1'b0, p1_read = 1'b0, p1_write = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_ack, p0_rvalid, p1_ack, p1_rvalid, mem_read, mem_write;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
`ifdef MEM_ARB_LOCK_EN
    logic          p0_lock = 1'b0, p1_lock = 1'b0;
`endif

    int            n_checks = 0;
    int            n_fail = 0;
    logic          last_port = 1'b1;
    logic [DW-1:0] env_mem [int];
    logic [DW-1:0] ref_mem [int];
    logic          c_act [2];
    logic          c_rd [2];
    logic          c_wr [2];
    logic [AW-1:0] c_ad [2];
    logic [DW-1:0] c_wd [2];

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rvalid(p0_rvalid),
        .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rvalid(p1_rvalid),
`ifdef MEM_ARB_LOCK_EN
        .p0_lock(p0_lock), .p1_lock(p1_lock),
`endif
        .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(int a);
        return DW'(a * 7 + 3);
    endfunction

    function automatic logic [DW-1:0] ref_val(int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // single-port memory with registered read data
    always @(posedge clk) begin
        if (mem_write) env_mem[int'(mem_addr)] = mem_wdata;
        if (mem_read) mem_rdata <= env_mem.exists(int'(mem_addr)) ? env_mem[int'(mem_addr)] : init_val(int'(mem_addr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        p0_read = 1'b0; p0_write = 1'b0; p1_read = 1'b0; p1_write = 1'b0;
    endtask

    task automatic settle();
        idle_all();
        repeat (3) tick();
    endtask

    task automatic apply();
        p0_read = c_act[0] & c_rd[0]; p0_write = c_act[0] & c_wr[0]; p0_addr = c_ad[0]; p0_wdata = c_wd[0];
        p1_read = c_act[1] & c_rd[1]; p1_write = c_act[1] & c_wr[1]; p1_addr = c_ad[1]; p1_wdata = c_wd[1];
    endtask

    task automatic new_req(int k);
        int kind;
        kind = $urandom_range(0, 2);
        c_act[k] = 1'b1;
        c_rd[k]  = kind != 1;
        c_wr[k]  = kind != 0;
        c_ad[k]  = AW'($urandom_range(0, 31));
        c_wd[k]  = DW'($urandom);
    endtask

    // exclusivity of strobes and rvalid one cycle after a read ack, checked every cycle
    task automatic watch_invariants();
        logic pa0 = 1'b0, pa1 = 1'b0, pr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pa0 = 1'b0; pa1 = 1'b0; pr = 1'b0;
            end else begin
                n_checks++;
                if ((p0_ack & p1_ack) | (p0_rvalid & p1_rvalid) | (mem_read & mem_write) | (p0_ack & p0_rvalid) | (p1_ack & p1_rvalid)) begin
                    n_fail++;
                    $display("FAIL exclusive: ack=%b%b rvalid=%b%b rd=%b wr=%b, required at most one of each", p1_ack, p0_ack, p1_rvalid, p0_rvalid, mem_read, mem_write);
                end
                n_checks++;
                if ((p0_ack | p1_ack) !== (mem_read | mem_write)) begin
                    n_fail++;
                    $display("FAIL ack_strobe: ack=%b%b strobes rd=%b wr=%b, required ack with strobe", p1_ack, p0_ack, mem_read, mem_write);
                end
                n_checks++;
                if ({p1_rvalid, p0_rvalid} !== {pa1 & pr, pa0 & pr}) begin
                    n_fail++;
                    $display("FAIL rvalid_timing: rvalid=%b%b required %b%b", p1_rvalid, p0_rvalid, pa1 & pr, pa0 & pr);
                end
                pa0 = p0_ack; pa1 = p1_ack; pr = mem_read;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        repeat (2) tick();
        n_checks++;
        if ({mem_read, mem_write, p0_ack, p1_ack, p0_rvalid, p1_rvalid} !== 6'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: strobes=%b addr=%h wdata=%h, required all zero",
                     {mem_read, mem_write, p0_ack, p1_ack, p0_rvalid, p1_rvalid}, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        last_port = 1'b1;
        tick();
        n_checks++;
        if ({p0_ack, p1_ack, mem_read, mem_write} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_quiet: ack/strobes=%b required 0000", {p0_ack, p1_ack, mem_read, mem_write});
        end
    endtask

    task automatic test_write_read();
        p0_write = 1'b1; p0_addr = 16'h0010; p0_wdata = 8'hA5;
        tick();
        n_checks++;
        if ({mem_write, mem_read, p0_ack, p1_ack} !== 4'b1010 || mem_addr !== 16'h0010 || mem_wdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL p0_write: wr/rd/ack0/ack1=%b addr=%h wdata=%h, required 1010 0010 a5",
                     {mem_write, mem_read, p0_ack, p1_ack}, mem_addr, mem_wdata);
        end
        ref_mem[16] = 8'hA5;
        last_port = 1'b0;
        idle_all();
        tick();
        p1_read = 1'b1; p1_addr = 16'h0010;
        tick();
        n_checks++;
        if ({mem_read, mem_write, p1_ack, p0_ack} !== 4'b1010 || mem_addr !== 16'h0010) begin
            n_fail++;
            $display("FAIL p1_read_ack: rd/wr/ack1/ack0=%b addr=%h, required 1010 0010", {mem_read, mem_write, p1_ack, p0_ack}, mem_addr);
        end
        last_port = 1'b1;
        idle_all();
        tick();
        n_checks++;
        if (p1_rvalid !== 1'b1 || rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL p1_read_data: rvalid=%b rdata=%h, required 1 a5", p1_rvalid, rdata);
        end
        p0_read = 1'b1; p0_addr = 16'h0020;
        tick();
        n_checks++;
        if (p0_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL early_grant: p0_ack=%b in cycle after rvalid, required 0", p0_ack);
        end
        tick();
        n_checks++;
        if (p0_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL next_grant: p0_ack=%b required 1", p0_ack);
        end
        idle_all();
        last_port = 1'b0;
        tick();
        n_checks++;
        if (p0_rvalid !== 1'b1 || rdata !== ref_val(32)) begin
            n_fail++;
            $display("FAIL p0_read_data: rvalid=%b rdata=%h, required 1 %h", p0_rvalid, rdata, ref_val(32));
        end
        settle();
    endtask

    task automatic test_round_robin();
        int acks [2];
        int last_ack = -1;
        logic rv_due = 1'b0, rv_port = 1'b0;
        logic [DW-1:0] rv_exp = '0;
        acks[0] = 0; acks[1] = 0;
        p0_read = 1'b1; p1_read = 1'b1;
        p0_addr = AW'($urandom_range(0, 31)); p1_addr = AW'($urandom_range(0, 31));
        for (int c = 0; c < 100 && acks[0] + acks[1] < 16; c++) begin
            tick();
            if (rv_due) begin
                n_checks++;
                if ({p1_rvalid, p0_rvalid} !== (rv_port ? 2'b10 : 2'b01) || rdata !== rv_exp) begin
                    n_fail++;
                    $display("FAIL rr_rdata: rvalid=%b%b rdata=%h, required port %0d data %h", p1_rvalid, p0_rvalid, rdata, rv_port, rv_exp);
                end
                rv_due = 1'b0;
            end
            if (p0_ack | p1_ack) begin
                logic p;
                p = p1_ack;
                n_checks++;
                if (p !== ~last_port) begin
                    n_fail++;
                    $display("FAIL rr_order: granted port %0d required port %0d", p, ~last_port);
                end
                n_checks++;
                if (mem_addr !== (p ? p1_addr : p0_addr) || mem_read !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rr_issue: addr=%h rd=%b, required %h 1", mem_addr, mem_read, p ? p1_addr : p0_addr);
                end
                if (last_ack >= 0) begin
                    n_checks++;
                    if (c - last_ack !== 3) begin
                        n_fail++;
                        $display("FAIL rr_spacing: %0d cycles between grants, required 3", c - last_ack);
                    end
                end
                rv_due = 1'b1; rv_port = p; rv_exp = ref_val(int'(p ? p1_addr : p0_addr));
                last_port = p; acks[p]++; last_ack = c;
                if (p) p1_addr = AW'($urandom_range(0, 31));
                else p0_addr = AW'($urandom_range(0, 31));
            end
        end
        idle_all();
        tick();
        if (rv_due) begin
            n_checks++;
            if ({p1_rvalid, p0_rvalid} !== (rv_port ? 2'b10 : 2'b01) || rdata !== rv_exp) begin
                n_fail++;
                $display("FAIL rr_rdata_last: rvalid=%b%b rdata=%h, required port %0d data %h", p1_rvalid, p0_rvalid, rdata, rv_port, rv_exp);
            end
        end
        n_checks++;
        if (acks[0] !== 8 || acks[1] !== 8) begin
            n_fail++;
            $display("FAIL rr_count: acks p0=%0d p1=%0d, required 8 and 8", acks[0], acks[1]);
        end
        settle();
    endtask

    task automatic test_rw_both();
        int got = 0;
        logic exp_p;
        exp_p = ~last_port;
        p0_read = 1'b1; p0_write = 1'b1; p0_addr = 16'h0030; p0_wdata = 8'h3C;
        p1_read = 1'b1; p1_write = 1'b1; p1_addr = 16'h0031; p1_wdata = 8'hC3;
        for (int c = 0; c < 20 && got < 2; c++) begin
            tick();
            n_checks++;
            if (p0_rvalid | p1_rvalid | mem_read) begin
                n_fail++;
                $display("FAIL rw_as_write: rvalid=%b%b mem_read=%b, required 000", p1_rvalid, p0_rvalid, mem_read);
            end
            if (p0_ack | p1_ack) begin
                logic p;
                p = p1_ack;
                n_checks++;
                if (p !== exp_p || mem_write !== 1'b1 || mem_wdata !== (p ? 8'hC3 : 8'h3C)) begin
                    n_fail++;
                    $display("FAIL rw_grant: port %0d wr=%b wdata=%h, required port %0d wr 1 data %h",
                             p, mem_write, mem_wdata, exp_p, exp_p ? 8'hC3 : 8'h3C);
                end
                ref_mem[p ? 49 : 48] = p ? 8'hC3 : 8'h3C;
                last_port = p; exp_p = ~p; got++;
                if (p) begin p1_read = 1'b0; p1_write = 1'b0; end
                else begin p0_read = 1'b0; p0_write = 1'b0; end
            end
        end
        n_checks++;
        if (got !== 2) begin
            n_fail++;
            $display("FAIL rw_count: %0d grants, required 2", got);
        end
        settle();
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock();
        int p1_acks = 0;
        int rel = 0;
        logic done = 1'b0;
        p1_lock = 1'b1; p1_write = 1'b1; p1_addr = AW'($urandom_range(0, 31)); p1_wdata = DW'($urandom);
        for (int c = 0; c < 60 && !done; c++) begin
            tick();
            if (p0_ack) begin
                n_checks++;
                if (p1_acks !== 4 || c - rel !== 2) begin
                    n_fail++;
                    $display("FAIL lock_release: p0 granted after %0d p1 acks, %0d cycles after last, required 4 and 2", p1_acks, c - rel);
                end
                ref_mem[int'(p0_addr)] = p0_wdata;
                last_port = 1'b0; done = 1'b1; p0_write = 1'b0;
            end
            if (p1_ack) begin
                ref_mem[int'(p1_addr)] = p1_wdata;
                last_port = 1'b1; p1_acks++; rel = c;
                p0_write = 1'b1; p0_addr = 16'h0005; p0_wdata = 8'h5A;
                if (p1_acks == 4) begin p1_write = 1'b0; p1_lock = 1'b0; end
                else begin p1_addr = AW'($urandom_range(0, 31)); p1_wdata = DW'($urandom); end
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL lock_timeout: p0 never granted, p1 acks=%0d", p1_acks);
        end
        settle();
    endtask
`endif

    task automatic test_random();
        int free_at = 0;
        logic rv_due = 1'b0, rv_port = 1'b0;
        logic [DW-1:0] rv_exp = '0;
        for (int k = 0; k < 2; k++) c_act[k] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic [1:0] pend;
            logic g, p, w;
            for (int k = 0; k < 2; k++) if (!c_act[k] && $urandom_range(0, 2) == 0) new_req(k);
            apply();
            pend = {c_act[1], c_act[0]};
            p = (pend == 2'b11) ? ~last_port : pend[1];
            g = c >= free_at && pend != 2'b00;
            w = c_wr[p];
            tick();
            if (rv_due) begin
                n_checks++;
                if ({p1_rvalid, p0_rvalid} !== (rv_port ? 2'b10 : 2'b01) || rdata !== rv_exp) begin
                    n_fail++;
                    $display("FAIL rand_rdata: rvalid=%b%b rdata=%h, required port %0d data %h", p1_rvalid, p0_rvalid, rdata, rv_port, rv_exp);
                end
                rv_due = 1'b0;
            end
            n_checks++;
            if ({p1_ack, p0_ack} !== (g ? (p ? 2'b10 : 2'b01) : 2'b00)) begin
                n_fail++;
                $display("FAIL rand_grant: cycle %0d ack=%b%b required %b", c, p1_ack, p0_ack, g ? (p ? 2'b10 : 2'b01) : 2'b00);
            end
            if (g) begin
                n_checks++;
                if (mem_write !== w || mem_read !== ~w || mem_addr !== c_ad[p] || (w && mem_wdata !== c_wd[p])) begin
                    n_fail++;
                    $display("FAIL rand_issue: wr=%b rd=%b addr=%h wdata=%h, required wr %b addr %h wdata %h",
                             mem_write, mem_read, mem_addr, mem_wdata, w, c_ad[p], c_wd[p]);
                end
                if (w) ref_mem[int'(c_ad[p])] = c_wd[p];
                else begin rv_due = 1'b1; rv_port = p; rv_exp = ref_val(int'(c_ad[p])); end
                last_port = p;
                free_at = c + (w ? 2 : 3);
                c_act[p] = 1'b0;
                if ($urandom_range(0, 1) == 1) new_req(int'(p));
            end
        end
        for (int k = 0; k < 2; k++) c_act[k] = 1'b0;
        apply();
        tick();
        if (rv_due) begin
            n_checks++;
            if ({p1_rvalid, p0_rvalid} !== (rv_port ? 2'b10 : 2'b01) || rdata !== rv_exp) begin
                n_fail++;
                $display("FAIL rand_rdata_last: rvalid=%b%b rdata=%h, required port %0d data %h", p1_rvalid, p0_rvalid, rdata, rv_port, rv_exp);
            end
        end
        settle();
    endtask

    task automatic test_reset_mid();
        p1_read = 1'b1; p1_addr = 16'h0011;
        tick();
        n_checks++;
        if (p1_ack !== 1'b1 || mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: p1_ack=%b mem_read=%b, required 1 1", p1_ack, mem_read);
        end
        idle_all();
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_read, mem_write, p0_ack, p1_ack, p0_rvalid, p1_rvalid} !== 6'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: strobes=%b addr=%h wdata=%h, required all zero",
                     {mem_read, mem_write, p0_ack, p1_ack, p0_rvalid, p1_rvalid}, mem_addr, mem_wdata);
        end
        tick();
        n_checks++;
        if (p1_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_rvalid: p1_rvalid=%b required 0", p1_rvalid);
        end
        p0_read = 1'b1; p0_addr = 16'h0012; p1_read = 1'b1; p1_addr = 16'h0013;
        rst = 1'b0;
        last_port = 1'b1;
        tick();
        n_checks++;
        if ({p1_ack, p0_ack} !== 2'b01) begin
            n_fail++;
            $display("FAIL post_reset_first: ack=%b%b required 01", p1_ack, p0_ack);
        end
        last_port = 1'b0;
        settle();
    endtask

    initial begin
        fork
            watch_invariants();
        join_none
        test_reset();
        test_write_read();
        test_round_robin();
        test_rw_both();
`ifdef MEM_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter in front of the single-port byte memory (1-cycle read latency, registered read data).
- Lets the UART command controller (port 0) and a second client (port 1) share one memory instance.
- Round-robin fairness, one access in flight at a time, per-port acknowledge and read-data-valid strobes.

Parameters:
- ADDR_WIDTH, 16, address width for both ports and the memory.
- DATA_WIDTH, 8, data width for both ports and the memory.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_read  in  1  port 0 read request, level, held until p0_ack.
- p0_write  in  1  port 0 write request, level, held until p0_ack.
- p0_addr  in  ADDR_WIDTH  port 0 address, stable while request held.
- p0_wdata  in  DATA_WIDTH  port 0 write data, stable while request held.
- p0_ack  out  1  one-cycle pulse: port 0 request issued to memory this cycle.
- p0_rvalid  out  1  one-cycle pulse: rdata holds port 0 read result.
- p1_read, p1_write, p1_addr, p1_wdata, p1_ack, p1_rvalid: same as port 0, for port 1.
- rdata  out  DATA_WIDTH  shared read data, direct from mem_rdata.
- mem_read  out  1  memory read strobe, registered.
- mem_write  out  1  memory write strobe, registered.
- mem_addr  out  ADDR_WIDTH  memory address, registered.
- mem_wdata  out  DATA_WIDTH  memory write data, registered.
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_read.
- p0_lock, p1_lock  in  1  only with MEM_ARB_LOCK_EN.

Behaviour:
- Reset (async, active-high): state IDLE; all strobes 0; mem_addr/mem_wdata 0; owner 0; last_served = 1, so port 0 wins first.
- Request priority within a port: read and write both set is treated as a write.
- States:
  - IDLE: a port is pending if read|write is set. One pending port wins. Both pending: the port != last_served wins. On grant, register mem_read/mem_write/mem_addr/mem_wdata and pX_ack; latch owner; set last_served = owner; go to ISSUE.
  - ISSUE: strobes and ack are high for exactly this cycle. Read goes to DATA; write goes to IDLE.
  - DATA: owner's pX_rvalid = 1 and rdata = mem_rdata; go to IDLE.
- Latency from request sampled high in IDLE (cycle 0):
  - Write: ack and mem_write in cycle 1; next arbitration in cycle 2.
  - Read: ack and mem_read in cycle 1; rvalid in cycle 2; next arbitration in cycle 3.
- Handshake: the requester must drop its request, or present a new one, in the cycle after ack. Requests are not sampled in ISSUE or DATA.
- A request arriving during ISSUE/DATA waits; it is never lost.
- ack and rvalid are never both high for the same port in the same cycle. The two ports' strobes are mutually exclusive.
- Address/data pass through unchanged; no width conversion or arithmetic.
- Reset mid-operation: in-flight strobes cleared immediately; no rvalid is produced for the aborted access.

Optional Feature:
- MEM_ARB_LOCK_EN defined:
  - pX_lock ports exist.
  - If the owner's lock is high when it is granted, the arbiter enters LOCKED instead of running round-robin: in IDLE only the owner is considered. The other port waits even if pending.
  - Release happens at the first IDLE cycle with owner lock low; last_served is then updated normally.
  - Intended for multi-byte command bursts.
- MEM_ARB_LOCK_EN undefined: ports absent; pure round-robin.

Decomposition:
- Shared include (mem_defs.v): state encodings (IDLE, ISSUE, DATA, LOCKED), port index constants PORT0/PORT1, default ADDR_WIDTH/DATA_WIDTH. Guard it against multiple inclusion.
- Optional sub-module rr_pick2: combinational two-way round-robin chooser (inputs: pending[1:0], last_served; outputs: grant, grant_idx). Everything else stays flat.

Test Plan:
- After reset, p0 writes 0xA5 to 0x0010 -> mem_write=1, mem_addr=0x0010, mem_wdata=0xA5 and p0_ack=1 in cycle 1; no p1 strobes.
- p1 reads 0x0010 after the write above -> p1_ack in cycle 1, p1_rvalid with rdata=0xA5 in cycle 2; next grant no earlier than cycle 3.
- p0 and p1 both read continuously (held requests) -> grants alternate p0,p1,p0,p1; each gets exactly one ack per access; no starvation over 16 accesses.
- Assert rst during ISSUE of a p1 read -> all outputs 0 immediately; no p1_rvalid; after release, simultaneous requests grant p0 first.
- p0 and p1 both assert read and write -> treated as writes; only mem_write pulses; no rvalid.
- MEM_ARB_LOCK_EN: p1 locks and does 4 writes while p0 is pending -> all 4 p1 acks precede p0_ack; p0 is granted the first IDLE after p1_lock drops.
